ysyx_22050019_mem_responder: RTL and testbench
==============================================

YSYX_22050019_MEM_RESPONDER -- requirements
Module: ysyx_22050019_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning log2 of the word count (64-bit words) of internal storage.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to response valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port arvalid  input  1  read request valid.
REQ-006 SHALL have port arready  output  1  read request accepted when arvalid and arready are both high at a clk edge.
REQ-007 SHALL have port araddr  input  64  read byte address.
REQ-008 SHALL have port rvalid  output  1  read data valid.
REQ-009 SHALL have port rready  input  1  requester accepts read data.
REQ-010 SHALL have port rdata  output  64  read data.
REQ-011 SHALL have port awvalid  input  1  write request valid.
REQ-012 SHALL have port awready  output  1  write request accepted when awvalid and awready are both high at a clk edge.
REQ-013 SHALL have port awaddr  input  64  write byte address.
REQ-014 SHALL have port wdata  input  64  write data.
REQ-015 SHALL have port wstrb  input  8  byte enables; bit i enables wdata[8i+7:8i].
REQ-016 SHALL have port bvalid  output  1  write completion valid.
REQ-017 SHALL have port bready  input  1  requester accepts write completion.

Function
REQ-018 SHALL hold 2^ADDR_W x 64-bit storage, indexed by addr[ADDR_W+2:3]; addr[2:0] and bits above ADDR_W+2 ignored (aliasing wrap).
REQ-019 SHALL implement FSM states IDLE, RBUSY, RRESP, WBUSY, WRESP; one transaction outstanding at a time.
REQ-020 SHALL drive arready = 1 only in IDLE.
REQ-021 SHALL drive awready = 1 only in IDLE with arvalid low (read has priority on simultaneous requests).
REQ-022 SHALL on read accept: IDLE->RBUSY, latch word index, load latency counter with LATENCY-1.
REQ-023 SHALL on write accept: commit wdata bytes selected by wstrb into storage at that same edge, IDLE->WBUSY, load counter with LATENCY-1.
REQ-024 SHALL in RBUSY/WBUSY decrement counter each cycle; at counter==0 move to RRESP/WRESP, so rvalid/bvalid rise exactly LATENCY cycles after the accept edge.
REQ-025 SHALL on entering RRESP register storage[index] into rdata; rdata and rvalid held stable while rvalid & !rready.
REQ-026 SHALL in RRESP with rready high at an edge: rvalid->0, ->IDLE; rdata retains last value.
REQ-027 SHALL in WRESP with bready high at an edge: bvalid->0, ->IDLE.
REQ-028 SHALL ignore arvalid/awvalid outside IDLE; inputs need not be held after accept.
REQ-029 SHALL accept a new request at earliest the cycle after the response handshake (IDLE for at least one cycle).
REQ-030 SHALL treat wstrb = 0x00 as a legal write that changes no storage and still produces bvalid.

Reset
REQ-031 SHALL on rst high, regardless of state: state->IDLE, rvalid=0, bvalid=0, rdata=0, counter=0, asynchronously.
REQ-032 SHALL not reset storage contents; an in-flight write committed at its accept edge remains committed.
REQ-033 SHALL present arready=1 (and awready=!arvalid) in the first cycle after rst deasserts.

Verification (LATENCY=2, ADDR_W=8)
REQ-034 SHALL pass: write 0x1122334455667788 at 0x10, wstrb 0xFF, bready=1 -> bvalid at accept+2; then read 0x10 -> rvalid at accept+2, rdata=0x1122334455667788.
REQ-035 SHALL pass: write 0xAAAAAAAABBBBBBBB at 0x10, wstrb 0x0F -> subsequent read 0x10 returns 0x11223344BBBBBBBB.
REQ-036 SHALL pass: arvalid and awvalid both high in IDLE -> arready=1, awready=0; read completes first; write accepted only after read response handshake plus one IDLE cycle.
REQ-037 SHALL pass: read with rready low 3 cycles after rvalid -> rvalid and rdata stable, arready=0 for those cycles; rready=1 -> rvalid=0 next cycle.
REQ-038 SHALL pass: rst pulsed while in RBUSY -> rvalid=0, rdata=0 immediately; after deassert arready=1 and a new read of 0x10 returns stored data.
REQ-039 SHALL pass: write 0xDEADBEEF00000001 at 0x800 -> read at 0x000 returns 0xDEADBEEF00000001 (alias wrap); read at 0x807 returns same word.

Source files
------------

// File: rtl/ysyx_22050019_mem_responder.sv
`timescale 1ns/1ps
// ysyx_22050019_mem_responder
// Single-outstanding memory responder: 2^ADDR_W x 64-bit storage served over
// a simplified AR/R and AW(+W)/B handshake with a fixed response latency.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   arvalid/arready/araddr   read request (byte address, word-aligned index)
//   rvalid/rready/rdata      read response, held until accepted
//   awvalid/awready/awaddr   write request, with wdata/wstrb in the same beat
//   wdata/wstrb              write data and byte enables
//   bvalid/bready            write completion
module ysyx_22050019_mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  output logic        arready,
  input  logic [63:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [63:0] rdata,
  input  logic        awvalid,
  output logic        awready,
  input  logic [63:0] awaddr,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned STRB_W   = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RBUSY = 3'd1,
    RRESP = 3'd2,
    WBUSY = 3'd3,
    WRESP = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               rvalid_d, bvalid_d;
  logic [DATA_W-1:0]  rdata_d;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               rd_acc, wr_acc;
  logic [ADDR_W-1:0]  rd_idx, wr_idx;
  logic               unused_addr_bits;

  // Word index from byte address; offset and high bits alias away.
  assign rd_idx = araddr[ADDR_W+2:3];
  assign wr_idx = awaddr[ADDR_W+2:3];
  assign unused_addr_bits = ^{araddr[63:ADDR_W+3], araddr[2:0],
                              awaddr[63:ADDR_W+3], awaddr[2:0]};

  // Request acceptance; reads win over simultaneous writes.
  assign arready = (state_q == IDLE);
  assign awready = (state_q == IDLE) && !arvalid;
  assign rd_acc  = arvalid && arready;
  assign wr_acc  = awvalid && awready;

  // Storage is not reset; a write commits on its accept edge.
  always_ff @(posedge clk) begin : mem_write
    if (wr_acc && !rst) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // State and response registers.
  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rvalid  <= 1'b0;
      bvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rvalid  <= rvalid_d;
      bvalid  <= bvalid_d;
      rdata   <= rdata_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin : next_state
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rvalid_d = rvalid;
    bvalid_d = bvalid;
    rdata_d  = rdata;
    unique case (state_q)
      IDLE: begin
        if (rd_acc) begin
          state_d = RBUSY;
          idx_d   = rd_idx;
          cnt_d   = CNT_LOAD;
        end else if (wr_acc) begin
          state_d = WBUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      RBUSY: begin
        if (cnt_q == '0) begin
          state_d  = RRESP;
          rvalid_d = 1'b1;
          rdata_d  = mem[idx_q];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RRESP: begin
        if (rready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      WBUSY: begin
        if (cnt_q == '0) begin
          state_d  = WRESP;
          bvalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WRESP: begin
        if (bready) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22050019_mem_responder.sv
`timescale 1ns/1ps
// Testbench for ysyx_22050019_mem_responder: transaction-level model with
// per-cycle output comparison, directed scenarios and randomized traffic.
module tb_ysyx_22050019_mem_responder;

  localparam int LAT = 2;
  localparam int AW  = 8;
  localparam int WORDS = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, bready = 1'b0;
  logic [63:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        arready, rvalid, awready, bvalid;
  logic [63:0] rdata;

  ysyx_22050019_mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tb_cyc   = 0;
  bit check_en = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, tb_cyc, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [63:0] m_mem [WORDS];
  bit          m_busy = 1'b0, m_is_read = 1'b0, m_rvalid = 1'b0, m_bvalid = 1'b0;
  logic [63:0] m_rdata = '0;
  int          m_word = 0, m_due = 0, m_cyc = 0;

  function automatic int word_of(input logic [63:0] a);
    return int'((a / 64'd8) % 64'(WORDS));
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r = old;
    for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  initial begin : cycle_count
    forever begin
      @(posedge clk);
      tb_cyc++;
    end
  end

  // One transaction at a time; response becomes visible LAT edges after accept.
  initial begin : model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 1'b0; m_rvalid = 1'b0; m_bvalid = 1'b0; m_rdata = '0;
      end else begin
        m_cyc++;
        if (!m_busy) begin
          if (arvalid) begin
            m_busy = 1'b1; m_is_read = 1'b1; m_word = word_of(araddr); m_due = m_cyc + LAT;
          end else if (awvalid) begin
            m_mem[word_of(awaddr)] = merge(m_mem[word_of(awaddr)], wdata, wstrb);
            m_busy = 1'b1; m_is_read = 1'b0; m_due = m_cyc + LAT;
          end
        end else if (m_rvalid) begin
          if (rready) begin m_rvalid = 1'b0; m_busy = 1'b0; end
        end else if (m_bvalid) begin
          if (bready) begin m_bvalid = 1'b0; m_busy = 1'b0; end
        end else if (m_cyc == m_due) begin
          if (m_is_read) begin m_rvalid = 1'b1; m_rdata = m_mem[m_word]; end
          else m_bvalid = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (check_en && !rst) begin
        chk("arready", 64'(arready), 64'(!m_busy));
        chk("awready", 64'(awready), 64'(!m_busy && !arvalid));
        chk("rvalid",  64'(rvalid),  64'(m_rvalid));
        chk("bvalid",  64'(bvalid),  64'(m_bvalid));
        chk("rdata",   rdata,        m_rdata);
      end
    end
  end

  // ---------------- drivers ----------------
  int acc_cyc = 0;
  int hs_cyc  = 0;

  task automatic send_read(input logic [63:0] a);
    int n = 0;
    logic acc = 1'b0;
    arvalid = 1'b1; araddr = a;
    while (!acc && n < 50) begin
      @(negedge clk); acc = arready;
      @(posedge clk); #1; n++;
    end
    arvalid = 1'b0; araddr = {$urandom, $urandom};
    acc_cyc = tb_cyc;
    chk("ar_accept", 64'(acc), 64'd1);
  endtask

  task automatic send_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    int n = 0;
    logic acc = 1'b0;
    awvalid = 1'b1; awaddr = a; wdata = d; wstrb = s;
    while (!acc && n < 50) begin
      @(negedge clk); acc = awready;
      @(posedge clk); #1; n++;
    end
    awvalid = 1'b0; awaddr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    wstrb = 8'($urandom);
    acc_cyc = tb_cyc;
    chk("aw_accept", 64'(acc), 64'd1);
  endtask

  // Wait for the response, stall the ready for 'stall' cycles, then handshake.
  task automatic wait_resp(input bit is_read, input int stall, output int lat,
                           output logic [63:0] d);
    int n = 0;
    int s = stall;
    bit done = 1'b0;
    logic v;
    lat = -1; d = '0;
    rready = 1'b0; bready = 1'b0;
    while (!done && n < 60) begin
      v = is_read ? rvalid : bvalid;
      if (v && lat < 0) begin lat = tb_cyc - acc_cyc; d = rdata; end
      if (v && s == 0) begin
        if (is_read) rready = 1'b1; else bready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        hs_cyc = tb_cyc;
        done = 1'b1;
      end else begin
        if (v) s--;
        @(posedge clk); #1;
      end
      n++;
    end
    chk(is_read ? "r_handshake" : "b_handshake", 64'(done), 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int lat;
    logic [63:0] d;
    int rd_hs;

    idle(3);
    rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    chk("post_reset_arready", 64'(arready), 64'd1);
    chk("post_reset_awready", 64'(awready), 64'd1);
    chk("post_reset_rvalid",  64'(rvalid),  64'd0);
    chk("post_reset_rdata",   rdata,        64'd0);
    @(posedge clk); #1;

    // Fill storage so every later read has a known value.
    for (int w = 0; w < WORDS; w++) begin
      send_write(64'(w * 8), {$urandom, $urandom}, 8'hFF);
      wait_resp(1'b0, 0, lat, d);
    end

    // Full write, then read back with latency checks.
    send_write(64'h10, 64'h1122334455667788, 8'hFF);
    wait_resp(1'b0, 0, lat, d);
    chk("wr_latency", 64'(lat), 64'd2);
    idle(1);
    send_read(64'h10);
    wait_resp(1'b1, 0, lat, d);
    chk("rd_latency", 64'(lat), 64'd2);
    chk("rd_full", d, 64'h1122334455667788);

    // Partial write with low-half strobes.
    send_write(64'h10, 64'hAAAAAAAABBBBBBBB, 8'h0F);
    wait_resp(1'b0, 0, lat, d);
    send_read(64'h10);
    wait_resp(1'b1, 0, lat, d);
    chk("rd_partial", d, 64'h11223344BBBBBBBB);

    // Zero strobe still completes and changes nothing.
    send_write(64'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    wait_resp(1'b0, 1, lat, d);
    chk("wr_zero_strb_latency", 64'(lat), 64'd2);
    send_read(64'h10);
    wait_resp(1'b1, 3, lat, d);
    chk("rd_after_zero_strb", d, 64'h11223344BBBBBBBB);

    // Simultaneous read and write: read first, write one IDLE cycle later.
    arvalid = 1'b1; araddr = 64'h10;
    awvalid = 1'b1; awaddr = 64'h18; wdata = 64'h0123456789ABCDEF; wstrb = 8'hFF;
    @(negedge clk);
    chk("both_arready", 64'(arready), 64'd1);
    chk("both_awready", 64'(awready), 64'd0);
    @(posedge clk); #1;
    acc_cyc = tb_cyc;
    arvalid = 1'b0;
    wait_resp(1'b1, 2, lat, d);
    chk("both_rd_data", d, 64'h11223344BBBBBBBB);
    rd_hs = hs_cyc;
    send_write(64'h18, 64'h0123456789ABCDEF, 8'hFF);
    chk("both_wr_after_idle", 64'(acc_cyc), 64'(rd_hs + 1));
    wait_resp(1'b0, 0, lat, d);

    // Reset during RBUSY clears the response registers immediately.
    send_read(64'h18);
    rst = 1'b1;
    #1;
    chk("rst_rvalid",  64'(rvalid),  64'd0);
    chk("rst_rdata",   rdata,        64'd0);
    chk("rst_arready", 64'(arready), 64'd1);
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_arready", 64'(arready), 64'd1);
    @(posedge clk); #1;
    send_read(64'h10);
    wait_resp(1'b1, 0, lat, d);
    chk("rd_after_rst", d, 64'h11223344BBBBBBBB);

    // Aliasing: high address bits and byte offset are ignored.
    send_write(64'h800, 64'hDEADBEEF00000001, 8'hFF);
    wait_resp(1'b0, 0, lat, d);
    send_read(64'h000);
    wait_resp(1'b1, 0, lat, d);
    chk("alias_0x000", d, 64'hDEADBEEF00000001);
    send_read(64'h807);
    wait_resp(1'b1, 0, lat, d);
    chk("alias_0x807", d, 64'hDEADBEEF00000001);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int t = 0; t < 300; t++) begin
      logic [63:0] a;
      logic [7:0]  s;
      int op;
      a  = {$urandom, $urandom};
      s  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      op = $urandom_range(0, 2);
      if (op == 0) begin
        send_read(a);
        wait_resp(1'b1, $urandom_range(0, 3), lat, d);
      end else if (op == 1) begin
        send_write(a, {$urandom, $urandom}, s);
        wait_resp(1'b0, $urandom_range(0, 3), lat, d);
      end else begin
        send_write(a, {$urandom, $urandom}, s);
        wait_resp(1'b0, 0, lat, d);
        send_read(a ^ 64'h7);
        wait_resp(1'b1, $urandom_range(0, 3), lat, d);
      end
      chk("rand_latency", 64'(lat), 64'(LAT));
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

endmodule
